// File: rtl/wb_nmx_cmd_slave.sv
// rtl/wb_nmx_cmd_slave.sv - Wishbone command/result responder for the neuromorphic array core
//
// Ports:
//   wb_clk_i, wb_rst_n            clock, async active-low reset (released synchronously inside)
//   wbs_stb_i/cyc_i/we_i/sel_i    Wishbone request
//   wbs_adr_i/dat_i/dat_o/ack_o   Wishbone address, data, single-cycle acknowledge
//   cmd_valid/ready, cmd_mode/row/col/data   command stream to the core (FIFO head)
//   res_valid/res_bit/res_ready   single-bit result stream from the core
module wb_nmx_cmd_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_000C,
    parameter int          CMD_DEPTH = 32,
    parameter int          RES_DEPTH = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_mode,
    output logic [4:0]  cmd_row,
    output logic [4:0]  cmd_col,
    output logic [19:0] cmd_data,
    input  logic        res_valid,
    input  logic        res_bit,
    output logic        res_ready
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0] RES_FULL = (RAW+1)'(RES_DEPTH);
    localparam logic [31:0]  STAT_ADDR = BASE_ADDR + 32'd4;

    // Reset asserts asynchronously but releases two edges later, in step with the clock.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic [CAW-1:0]       cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CAW:0]         cmd_cnt_q, cmd_cnt_d;
    logic [RAW-1:0]       res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [RAW:0]         res_cnt_q, res_cnt_d;
    logic [RES_DEPTH-1:0] res_mem_q, res_mem_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic [31:0]          cmd_mem [CMD_DEPTH];

    logic is_data, is_stat, acc, cmd_full, res_empty;
    logic cmd_push, cmd_pop, res_push, res_pop, busy;
    logic [31:0] status, head;

    function automatic logic [5:0] sat6(input logic [31:0] v);
        return (v > 32'd63) ? 6'd63 : v[5:0];
    endfunction

    assign is_data   = (wbs_adr_i == BASE_ADDR);
    assign is_stat   = (wbs_adr_i == STAT_ADDR);
    // One access per request: the cycle after an ack is forced idle.
    assign acc       = (is_data | is_stat) & wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign cmd_full  = (cmd_cnt_q == CMD_FULL);
    assign res_empty = (res_cnt_q == '0);
    assign cmd_valid = (cmd_cnt_q != '0);
    assign res_ready = (res_cnt_q != RES_FULL);
    assign cmd_push  = acc & wbs_we_i & is_data & (wbs_sel_i == 4'hF) & ~cmd_full;
    assign cmd_pop   = cmd_valid & cmd_ready;
    assign res_push  = res_valid & res_ready;
    assign res_pop   = acc & ~wbs_we_i & is_data & ~res_empty;
    assign busy      = cmd_valid | ~res_empty;
    assign status    = {13'b0, busy, udf_q, ovf_q, 2'b0, sat6(32'(res_cnt_q)),
                        2'b0, sat6(32'(cmd_cnt_q))};

    // Head is masked while empty so stale RAM contents never reach the core.
    assign head = cmd_valid ? cmd_mem[cmd_rp_q] : 32'h0;
    assign {cmd_mode, cmd_row, cmd_col, cmd_data} = head;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    always_comb begin
        ack_d     = acc;
        dat_d     = 32'h0;
        cmd_wp_d  = cmd_wp_q;
        cmd_rp_d  = cmd_rp_q;
        cmd_cnt_d = cmd_cnt_q;
        res_wp_d  = res_wp_q;
        res_rp_d  = res_rp_q;
        res_cnt_d = res_cnt_q;
        res_mem_d = res_mem_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (cmd_push) cmd_wp_d = cmd_wp_q + 1'b1;
        if (cmd_pop)  cmd_rp_d = cmd_rp_q + 1'b1;
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt_d = cmd_cnt_q + 1'b1;
            2'b01:   cmd_cnt_d = cmd_cnt_q - 1'b1;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase

        if (res_push) begin
            res_mem_d[res_wp_q] = res_bit;
            res_wp_d = res_wp_q + 1'b1;
        end
        if (res_pop) res_rp_d = res_rp_q + 1'b1;
        case ({res_push, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + 1'b1;
            2'b01:   res_cnt_d = res_cnt_q - 1'b1;
            default: res_cnt_d = res_cnt_q;
        endcase

        if (acc) begin
            if (is_data) begin
                if (wbs_we_i) begin
                    if (wbs_sel_i == 4'hF && cmd_full) ovf_d = 1'b1;
                end else if (res_empty) begin
                    udf_d = 1'b1;
                end else begin
                    dat_d = {31'b0, res_mem_q[res_rp_q]};
                end
            end else begin
                if (wbs_we_i) begin
                    if (wbs_dat_i[16]) ovf_d = 1'b0;
                    if (wbs_dat_i[17]) udf_d = 1'b0;
                end else begin
                    dat_d = status;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
            res_mem_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            cmd_cnt_q <= cmd_cnt_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            res_cnt_q <= res_cnt_d;
            res_mem_q <= res_mem_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Command storage needs no reset: entries are only visible through the masked head.
    always_ff @(posedge wb_clk_i) begin
        if (cmd_push) cmd_mem[cmd_wp_q] <= wbs_dat_i;
    end
endmodule

// File: tb/tb_wb_nmx_cmd_slave.sv
// tb/tb_wb_nmx_cmd_slave.sv - self-checking bench for wb_nmx_cmd_slave
module tb_wb_nmx_cmd_slave;
    localparam logic [31:0] DADR = 32'h3000_000C;
    localparam logic [31:0] SADR = 32'h3000_0010;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic [31:0] dat_o;
    logic        ack;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_mode;
    logic [4:0]  cmd_row, cmd_col;
    logic [19:0] cmd_data;
    logic        res_valid, res_bit, res_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_cmd[$];
    bit          m_res[$];
    bit          m_ovf, m_udf;

    wb_nmx_cmd_slave dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_bit(res_bit), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [5:0] cc, rc;
        cc = 6'(m_cmd.size());
        rc = 6'(m_res.size());
        return {13'b0, (m_cmd.size() != 0) || (m_res.size() != 0), m_udf, m_ovf,
                2'b0, rc, 2'b0, cc};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] r, output bit ok);
        adr = a; we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1;
        ok = 1'b0; r = 32'h0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(posedge clk); #1;
            if (ack) begin ok = 1'b1; r = dat_o; end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wb_ack adr=%h: no ack within 4 cycles, ack required", a);
        end
    endtask

    task automatic data_write(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r; bit ok;
        wb_xfer(DADR, 1'b1, s, d, r, ok);
        if (s == 4'hF) begin
            if (m_cmd.size() < DEPTH) m_cmd.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic data_read();
        logic [31:0] r, e; bit ok;
        if (m_res.size() != 0) e = {31'b0, m_res.pop_front()};
        else begin e = 32'h0; m_udf = 1'b1; end
        wb_xfer(DADR, 1'b0, 4'hF, 32'h0, r, ok);
        checks++;
        if (r !== e) begin errors++; $display("FAIL data_read got %h want %h", r, e); end
    endtask

    task automatic status_read(output logic [31:0] r);
        logic [31:0] e; bit ok;
        e = exp_status();
        wb_xfer(SADR, 1'b0, 4'hF, 32'h0, r, ok);
        checks++;
        if (r !== e) begin errors++; $display("FAIL status got %h want %h", r, e); end
    endtask

    task automatic status_w1c(input logic [31:0] d);
        logic [31:0] r; bit ok;
        wb_xfer(SADR, 1'b1, 4'hF, d, r, ok);
        if (d[16]) m_ovf = 1'b0;
        if (d[17]) m_udf = 1'b0;
    endtask

    task automatic core_pop();
        checks++;
        if (m_cmd.size() == 0) begin
            if (cmd_valid !== 1'b0) begin errors++; $display("FAIL cmd_valid_empty got %b want 0", cmd_valid); end
        end else begin
            if (cmd_valid !== 1'b1 || {cmd_mode, cmd_row, cmd_col, cmd_data} !== m_cmd[0]) begin
                errors++;
                $display("FAIL cmd_head got v=%b %h want v=1 %h", cmd_valid,
                         {cmd_mode, cmd_row, cmd_col, cmd_data}, m_cmd[0]);
            end
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            cmd_ready = 1'b0;
            void'(m_cmd.pop_front());
        end
    endtask

    task automatic core_result(input bit b);
        checks++;
        if (res_ready !== (m_res.size() < DEPTH)) begin
            errors++;
            $display("FAIL res_ready got %b want %b", res_ready, m_res.size() < DEPTH);
        end
        res_valid = 1'b1; res_bit = b;
        @(posedge clk); #1;
        res_valid = 1'b0;
        if (m_res.size() < DEPTH) m_res.push_back(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cmd.delete(); m_res.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++;
        if ({ack, dat_o, cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_data, res_ready} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs ack=%b dat=%h v=%b head=%h rr=%b want 0,0,0,0,1",
                     ack, dat_o, cmd_valid, {cmd_mode, cmd_row, cmd_col, cmd_data}, res_ready);
        end
        status_read(r);
    endtask

    task automatic test_cmd_fill();
        logic [31:0] r;
        cmd_ready = 1'b0;
        for (int i = 0; i < 33; i++)
            data_write({2'b11, 5'(i), 5'(i), (i % 2 == 0) ? 20'hFF : 20'h0}, 4'hF);
        status_read(r);
        checks++;
        if (r[5:0] !== 6'd32 || r[16] !== 1'b1) begin
            errors++; $display("FAIL fill_status cnt=%0d ovf=%b want 32,1", r[5:0], r[16]);
        end
        checks++;
        if ({cmd_mode, cmd_row, cmd_col, cmd_data} !== 32'hC000_00FF) begin
            errors++; $display("FAIL first_head got %h want c00000ff", {cmd_mode, cmd_row, cmd_col, cmd_data});
        end
        for (int i = 0; i < 32; i++) core_pop();
        core_pop();
        status_read(r);
    endtask

    task automatic test_result_path();
        logic [31:0] r;
        data_write(32'h4210_0000, 4'hF);
        checks++;
        if ({cmd_mode, cmd_row, cmd_col} !== 12'h421) begin
            errors++; $display("FAIL read_cmd_fields got %h want 421", {cmd_mode, cmd_row, cmd_col});
        end
        core_pop();
        core_result(1'b1);
        data_read();
        status_read(r);
        checks++;
        if (r[13:8] !== 6'd0) begin errors++; $display("FAIL res_cnt_after got %0d want 0", r[13:8]); end
    endtask

    task automatic test_underflow();
        logic [31:0] r;
        data_read();
        status_read(r);
        checks++;
        if (r[17] !== 1'b1) begin errors++; $display("FAIL rd_udf got %b want 1", r[17]); end
        status_w1c(32'h0003_0000);
        status_read(r);
        checks++;
        if (r[17:16] !== 2'b00) begin errors++; $display("FAIL w1c got %b want 00", r[17:16]); end
    endtask

    task automatic test_miss();
        logic [31:0] r;
        int acks = 0;
        data_write(32'h1234_5678, 4'hF);
        adr = 32'h3000_0008; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        checks++;
        if (acks != 0) begin errors++; $display("FAIL miss_acks got %0d want 0", acks); end
        status_read(r);
        core_pop();
    endtask

    task automatic test_res_full();
        logic [31:0] r;
        for (int i = 0; i < DEPTH + 1; i++) core_result(1'($urandom));
        status_read(r);
        checks++;
        if (r[13:8] !== 6'd32 || res_ready !== 1'b0) begin
            errors++; $display("FAIL res_full cnt=%0d rr=%b want 32,0", r[13:8], res_ready);
        end
        for (int i = 0; i < DEPTH; i++) data_read();
        status_read(r);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        bit          exp_ack[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit          got_ack[4];
        logic [31:0] got_dat[4];
        bit          pushed[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) core_result(pushed[i]);
        adr = DADR; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            got_ack[i] = ack; got_dat[i] = dat_o;
        end
        stb = 1'b0; cyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_ack[i] !== exp_ack[i]) begin
                errors++; $display("FAIL b2b_ack[%0d] got %b want %b", i, got_ack[i], exp_ack[i]);
            end
        end
        for (int i = 0; i < 4; i += 2) begin
            logic [31:0] e;
            e = {31'b0, m_res.pop_front()};
            checks++;
            if (got_dat[i] !== e) begin errors++; $display("FAIL b2b_dat[%0d] got %h want %h", i, got_dat[i], e); end
        end
        status_read(r);
        data_read();
        data_read();
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        for (int i = 0; i < 5; i++) data_write($urandom, 4'hF);
        core_result(1'b1);
        adr = DADR; we = 1'b1; sel = 4'hF; wdat = 32'hDEAD_BEEF; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack_before got %b want 1", ack); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset ack=%b v=%b want 0,0", ack, cmd_valid);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        do_reset();
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", cmd_valid); end
        status_read(r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL post_reset_status got %h want 0", r); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0, 1: data_write($urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
                2:    core_pop();
                3:    core_result(1'($urandom));
                4:    data_read();
                5:    status_read(r);
                default: status_w1c($urandom & 32'h0003_0000);
            endcase
        end
        status_read(r);
    endtask

    initial begin
        stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        cmd_ready = 0; res_valid = 0; res_bit = 0;
        do_reset();
        test_reset();
        test_cmd_fill();
        test_result_path();
        test_underflow();
        test_miss();
        test_res_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
